// File: rtl/cpu_axi_bridge_pkg.sv
// rtl/cpu_axi_bridge_pkg.sv - shared encodings, AXI constants and address translation for the CPU AXI bridge
package cpu_axi_bridge_pkg;

    typedef enum logic [1:0] {
        RS_IDLE     = 2'b00,
        RS_BUSY_IF  = 2'b01,
        RS_BUSY_MEM = 2'b10,
        RS_DONE     = 2'b11
    } read_state_e;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R, R_DONE} rd_fsm_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_B, W_DONE} wr_fsm_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_e;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_ID_IF      = 4'd0;
    localparam logic [3:0] AXI_ID_MEM     = 4'd1;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space
    function automatic logic [31:0] kseg_xlat(input logic [31:0] vaddr);
        if (vaddr[31:29] == 3'b100 || vaddr[31:29] == 3'b101)
            return {3'b000, vaddr[28:0]};
        return vaddr;
    endfunction

endpackage

// File: rtl/cpu_axi_write_fsm.sv
// rtl/cpu_axi_write_fsm.sv - single-beat AXI write channel sequencer for MEM-stage stores
module cpu_axi_write_fsm
    import cpu_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_sel,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              stall_mem,
    input  logic              flush,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,
    output logic              w_idle,
    output logic              w_done
);

    wr_fsm_e           state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        case (state_q)
            W_IDLE: begin
                if (mem_ce && mem_we) begin
                    awaddr_d  = kseg_xlat(mem_addr);
                    wdata_d   = mem_wdata;
                    wstrb_d   = mem_sel;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = W_ADDR;
                end
            end
            W_ADDR: begin
                // AW and W complete independently; wait for both before B
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = W_B;
                end
            end
            W_B: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    state_d  = W_DONE;
                end
            end
            W_DONE: begin
                if (flush || !stall_mem) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign awaddr  = awaddr_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign w_idle  = (state_q == W_IDLE);
    assign w_done  = (state_q == W_DONE);

endmodule

// File: rtl/cpu_axi_bridge.sv
// rtl/cpu_axi_bridge.sv - AXI4 master bridging MIPS32 IF/MEM ports with read arbitration and stall requests
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              stallreq_from_if,
    input  logic              mem_ce,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_sel,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq_from_mem,
    output logic [1:0]        axi_read_state,
    input  logic [5:0]        stall,
    input  logic              flush,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    rd_fsm_e           state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic w_idle, w_done;
    logic owner_stalled;
    logic unused_ok;

    cpu_axi_write_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_write_fsm (
        .clk       (clk),
        .rst       (rst),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_sel   (mem_sel),
        .mem_wdata (mem_wdata),
        .stall_mem (stall[4]),
        .flush     (flush),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready),
        .w_idle    (w_idle),
        .w_done    (w_done)
    );

    assign owner_stalled = (owner_q == OWN_MEM) ? stall[4] : stall[1];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        discard_d   = discard_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            R_IDLE: begin
                discard_d = 1'b0;
                // loads wait for an in-flight store so they never pass it
                if (mem_ce && !mem_we && w_idle) begin
                    owner_d   = OWN_MEM;
                    araddr_d  = kseg_xlat(mem_addr);
                    arvalid_d = 1'b1;
                    state_d   = R_AR;
                end else if (if_req) begin
                    owner_d   = OWN_IF;
                    araddr_d  = kseg_xlat(if_addr);
                    arvalid_d = 1'b1;
                    state_d   = R_AR;
                end
            end
            R_AR: begin
                if (flush) discard_d = 1'b1;
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R_R;
                end
            end
            R_R: begin
                if (flush) discard_d = 1'b1;
                if (rvalid && rlast) begin
                    rready_d = 1'b0;
                    if (discard_q || flush) begin
                        discard_d = 1'b0;
                        state_d   = R_IDLE;
                    end else begin
                        if (owner_q == OWN_MEM) mem_rdata_d = rdata;
                        else                    if_rdata_d  = rdata;
                        state_d = R_DONE;
                    end
                end
            end
            R_DONE: begin
                if (flush || !owner_stalled) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= R_IDLE;
            owner_q     <= OWN_IF;
            discard_q   <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            discard_q   <= discard_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        axi_read_state = RS_IDLE;
        case (state_q)
            R_AR, R_R: axi_read_state = (owner_q == OWN_MEM) ? RS_BUSY_MEM : RS_BUSY_IF;
            R_DONE:    axi_read_state = RS_DONE;
            default:   axi_read_state = RS_IDLE;
        endcase
    end

    assign stallreq_from_if  = if_req & ~(state_q == R_DONE && owner_q == OWN_IF);
    assign stallreq_from_mem = mem_ce & ~(mem_we ? w_done
                                                 : (state_q == R_DONE && owner_q == OWN_MEM));

    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    assign arid    = (owner_q == OWN_MEM) ? AXI_ID_MEM : AXI_ID_IF;
    assign araddr  = araddr_q;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = AXI_SIZE_WORD;
    assign arburst = AXI_BURST_INCR;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awid    = AXI_ID_MEM;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = AXI_SIZE_WORD;
    assign awburst = AXI_BURST_INCR;
    assign wlast   = 1'b1;

    // response codes are accepted as-is; only PC/ID/EX/WB stall bits are irrelevant here
    assign unused_ok = &{1'b0, rid, rresp, bresp, stall[5], stall[3:2], stall[0]};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb/tb_cpu_axi_bridge.sv - scoreboard bench for cpu_axi_bridge with a single-beat AXI slave model
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        stallreq_from_if;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq_from_mem;
    logic [1:0]  axi_read_state;
    logic [5:0]  stall;
    logic        flush;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        b_hold;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [31:0] addr; logic [3:0] id; } ar_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } w_exp_t;
    ar_exp_t ar_q[$];
    w_exp_t  w_q[$];

    always #5 clk = ~clk;

    cpu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .stallreq_from_if(stallreq_from_if),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stallreq_from_mem(stallreq_from_mem), .axi_read_state(axi_read_state),
        .stall(stall), .flush(flush),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_F00D;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] st, input int max, input string tag);
        int n = 0;
        while (n < max) begin
            @(negedge clk);
            if (axi_read_state == st) break;
            n++;
        end
        check_eq(tag, 32'(n < max), 32'd1);
    endtask

    // slave: samples handshakes mid-cycle, updates its outputs just after the edge
    initial begin
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got, b_pend;
        logic [31:0] ar_addr_s;
        logic [3:0]  ar_id_s;
        ar_exp_t ae;
        w_exp_t  we;
        rvalid = 0; rdata = 0; rid = 0; rresp = 0; rlast = 0; bvalid = 0; bresp = 0;
        aw_got = 0; w_got = 0; b_pend = 0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid & arready;
            r_hs  = rvalid & rready;
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            b_hs  = bvalid & bready;
            ar_addr_s = araddr;
            ar_id_s   = arid;
            if (ar_hs) begin
                check_eq("ar_expected", 32'(ar_q.size() != 0), 32'd1);
                if (ar_q.size() != 0) begin
                    ae = ar_q.pop_front();
                    check_eq("araddr", araddr, ae.addr);
                    check_eq("arid", {28'd0, arid}, {28'd0, ae.id});
                    check_eq("ar_attr", {19'd0, arlen, arsize, arburst}, {19'd0, 8'd0, 3'b010, 2'b01});
                end
            end
            if (aw_hs && w_q.size() != 0) begin
                check_eq("awaddr", awaddr, w_q[0].addr);
                check_eq("aw_attr", {15'd0, awid, awlen, awsize, awburst},
                         {15'd0, 4'd1, 8'd0, 3'b010, 2'b01});
            end
            if (w_hs) begin
                check_eq("w_expected", 32'(w_q.size() != 0), 32'd1);
                if (w_q.size() != 0) begin
                    we = w_q.pop_front();
                    check_eq("wdata", wdata, we.data);
                    check_eq("wstrb_wlast", {27'd0, wlast, wstrb}, {27'd0, 1'b1, we.strb});
                end
            end
            @(posedge clk);
            #1;
            if (rst) begin
                rvalid = 0; bvalid = 0; aw_got = 0; w_got = 0; b_pend = 0;
            end else begin
                if (r_hs) rvalid = 0;
                if (ar_hs) begin
                    rvalid = 1; rdata = word_of(ar_addr_s); rid = ar_id_s; rlast = 1; rresp = 0;
                end
                if (aw_hs) aw_got = 1;
                if (w_hs)  w_got  = 1;
                if (b_hs)  bvalid = 0;
                if (aw_got && w_got) begin
                    b_pend = 1; aw_got = 0; w_got = 0;
                end
                if (b_pend && !b_hold && !bvalid) begin
                    bvalid = 1; b_pend = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1; if_req = 1; if_addr = 0; mem_ce = 0; mem_we = 0; mem_addr = 0;
        mem_sel = 0; mem_wdata = 0; stall = 0; flush = 0; b_hold = 0;
        arready = 1; awready = 1; wready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check_eq("rst_state", {30'd0, axi_read_state}, 32'd0);
        check_eq("rst_if_rdata", if_rdata, 32'd0);
        check_eq("rst_mem_rdata", mem_rdata, 32'd0);
        check_eq("rst_addrs", araddr | awaddr | wdata, 32'd0);
        check_eq("rst_stallreq", {30'd0, stallreq_from_if, stallreq_from_mem}, 32'd2);
        step();
        rst = 0; if_req = 0;

        // IF fetch from kseg1 boot vector
        ar_q.push_back('{32'h1FC0_0000, 4'd0});
        if_req = 1; if_addr = 32'hBFC0_0000;
        @(negedge clk);
        check_eq("t1_c0", {30'd0, stallreq_from_if, arvalid}, 32'd2);
        step(); @(negedge clk);
        check_eq("t1_c1", {29'd0, arvalid, axi_read_state}, {29'd0, 1'b1, 2'b01});
        step(); @(negedge clk);
        check_eq("t1_c2", {30'd0, rready, stallreq_from_if}, 32'd3);
        step(); @(negedge clk);
        check_eq("t1_c3_state", {30'd0, axi_read_state}, 32'd3);
        check_eq("t1_c3_data", if_rdata, word_of(32'h1FC0_0000));
        check_eq("t1_c3_stallreq", {31'd0, stallreq_from_if}, 32'd0);
        step(); if_req = 0;
        @(negedge clk);
        check_eq("t1_c4_state", {30'd0, axi_read_state}, 32'd0);

        // simultaneous IF and MEM loads: MEM wins
        ar_q.push_back('{32'h0000_1000, 4'd1});
        ar_q.push_back('{32'h1FC0_0004, 4'd0});
        step();
        if_req = 1; if_addr = 32'hBFC0_0004;
        mem_ce = 1; mem_we = 0; mem_addr = 32'h8000_1000;
        step(); @(negedge clk);
        check_eq("t2_c1_state", {30'd0, axi_read_state}, 32'd2);
        step(); step(); @(negedge clk);
        check_eq("t2_c3_state", {30'd0, axi_read_state}, 32'd3);
        check_eq("t2_mem_data", mem_rdata, word_of(32'h0000_1000));
        check_eq("t2_stallreqs", {30'd0, stallreq_from_if, stallreq_from_mem}, 32'd2);
        step(); mem_ce = 0;
        wait_state(2'b11, 16, "t2_if_done_timeout");
        check_eq("t2_if_data", if_rdata, word_of(32'h1FC0_0004));
        step(); if_req = 0;

        // store with staggered AW/W readiness
        w_q.push_back('{32'h0000_2000, 32'h1234_5678, 4'b0011});
        awready = 0; wready = 0;
        mem_ce = 1; mem_we = 1; mem_addr = 32'hA000_2000; mem_sel = 4'b0011; mem_wdata = 32'h1234_5678;
        @(negedge clk);
        check_eq("t3_c0_stallreq", {31'd0, stallreq_from_mem}, 32'd1);
        step(); @(negedge clk);
        check_eq("t3_c1", {25'd0, awvalid, wvalid, bready, wstrb}, {25'd0, 3'b110, 4'b0011});
        step(); awready = 1; @(negedge clk);
        check_eq("t3_c2", {29'd0, awvalid, wvalid, bready}, 32'b110);
        step(); awready = 0; @(negedge clk);
        check_eq("t3_c3", {29'd0, awvalid, wvalid, bready}, 32'b010);
        step(); @(negedge clk);
        check_eq("t3_c4", {29'd0, awvalid, wvalid, bready}, 32'b010);
        step(); wready = 1; @(negedge clk);
        check_eq("t3_c5", {28'd0, awvalid, wvalid, bready, stallreq_from_mem}, 32'b0101);
        step(); wready = 0; @(negedge clk);
        check_eq("t3_c6", {29'd0, awvalid, wvalid, bready}, 32'b001);
        step(); @(negedge clk);
        check_eq("t3_c7_stallreq", {31'd0, stallreq_from_mem}, 32'd0);
        step(); mem_ce = 0; mem_we = 0; awready = 1; wready = 1;

        // flush while the read is in its data phase
        ar_q.push_back('{32'h1FC0_0010, 4'd0});
        step();
        if_req = 1; if_addr = 32'hBFC0_0010;
        step(); step(); flush = 1; @(negedge clk);
        check_eq("t4_c2_rready", {31'd0, rready}, 32'd1);
        step(); flush = 0; if_addr = 32'hBFC0_0020;
        ar_q.push_back('{32'h1FC0_0020, 4'd0});
        @(negedge clk);
        check_eq("t4_c3_state", {30'd0, axi_read_state}, 32'd0);
        check_eq("t4_c3_data_kept", if_rdata, word_of(32'h1FC0_0004));
        wait_state(2'b11, 16, "t4_refetch_timeout");
        check_eq("t4_refetch_data", if_rdata, word_of(32'h1FC0_0020));
        step(); if_req = 0;

        // IF stage stalled while its data sits in R_DONE
        ar_q.push_back('{32'h1FC0_0030, 4'd0});
        step();
        if_req = 1; if_addr = 32'hBFC0_0030;
        step(); step(); step();
        stall = 6'b000010;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) stall = 6'b000000;
            @(negedge clk);
            check_eq($sformatf("t5_hold%0d_state", k), {29'd0, arvalid, axi_read_state}, 32'b011);
            check_eq($sformatf("t5_hold%0d_data", k), if_rdata, word_of(32'h1FC0_0030));
            step();
        end
        if_req = 0;
        @(negedge clk);
        check_eq("t5_release_state", {30'd0, axi_read_state}, 32'd0);

        // load behind a store stuck waiting for its response
        w_q.push_back('{32'h0000_3000, 32'hCAFE_F00D, 4'b1111});
        b_hold = 1;
        step();
        mem_ce = 1; mem_we = 1; mem_addr = 32'h8000_3000; mem_sel = 4'b1111; mem_wdata = 32'hCAFE_F00D;
        step(); step();
        mem_we = 0; mem_addr = 32'h8000_4000;
        ar_q.push_back('{32'h0000_4000, 4'd1});
        @(negedge clk);
        check_eq("t6_c2", {30'd0, bready, arvalid}, 32'b10);
        step(); @(negedge clk);
        check_eq("t6_c3", {30'd0, arvalid, stallreq_from_mem}, 32'b01);
        step(); @(negedge clk);
        check_eq("t6_c4_arvalid", {31'd0, arvalid}, 32'd0);
        b_hold = 0;
        for (int k = 5; k < 8; k++) begin
            step(); @(negedge clk);
            check_eq($sformatf("t6_c%0d_arvalid", k), {31'd0, arvalid}, 32'd0);
        end
        step(); @(negedge clk);
        check_eq("t6_c8", {29'd0, arvalid, axi_read_state}, {29'd0, 1'b1, 2'b10});
        wait_state(2'b11, 16, "t6_load_timeout");
        check_eq("t6_mem_data", mem_rdata, word_of(32'h0000_4000));
        step(); mem_ce = 0;

        repeat (3) step();
        check_eq("ar_q_drained", ar_q.size(), 32'd0);
        check_eq("w_q_drained", w_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
